// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode encoding and the output-slot state type.
package alu_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_AND   = 2'b01,
        OP_XOR   = 2'b10,
        OP_PASSA = 2'b11
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HELD  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_arb_if.sv
// Request/response bundle for the two requesters sharing the ALU.
// The master side is the requesters, the slave side is alu_arb.
interface alu_arb_if;
    import alu_pkg::*;

    logic    req0_valid;
    logic    req0_ready;
    data_t   req0_a;
    data_t   req0_b;
    alu_op_e req0_op;
    logic    rsp0_valid;
    data_t   rsp0_data;
    logic    rsp0_ready;

    logic    req1_valid;
    logic    req1_ready;
    data_t   req1_a;
    data_t   req1_b;
    alu_op_e req1_op;
    logic    rsp1_valid;
    data_t   rsp1_data;
    logic    rsp1_ready;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_op, rsp1_ready,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data
    );

endinterface

// File: rtl/alu_arb_alu.sv
// Team 4-function ALU: ADD (mod 2^16), AND, XOR, PASSA. Purely combinational.
module alu_arb_alu
    import alu_pkg::*;
(
    input  data_t   a,
    input  data_t   b,
    input  alu_op_e op,
    output data_t   y
);

    // Select the function result for the current opcode.
    always_comb begin
        // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
        y = a;
        unique case (op)
            OP_ADD:   y = a + b;
            OP_AND:   y = a & b;
            OP_XOR:   y = a ^ b;
            OP_PASSA: y = a;
            default:  y = a;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// Two requesters share one ALU. The result lands in a single registered slot
// {state, owner, data}; a new grant is only possible when the slot is empty or
// its owner drains it in the same cycle.
module alu_arb
    import alu_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_arb_if.slave   bus
);

    slot_state_e state_q, state_d;
    logic        owner_q, owner_d;
    data_t       data_q,  data_d;
    logic        ptr_q,   ptr_d;     // 1 = requester 1 wins the next tie

    logic        drain;
    logic        slot_free;
    logic        gnt0, gnt1;
    data_t       alu_a, alu_b, alu_y;
    alu_op_e     alu_op;

    // Decide which requester (if any) may use the ALU this cycle.
    always_comb begin
        drain     = (state_q == SLOT_HELD) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
        slot_free = (state_q == SLOT_EMPTY) || drain;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (rst_n && slot_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if ((RR_EN != 0) && ptr_q) gnt1 = 1'b1;
                else                       gnt0 = 1'b1;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    // Route the granted requester's operands into the shared ALU.
    always_comb begin
        alu_a  = gnt1 ? bus.req1_a  : bus.req0_a;
        alu_b  = gnt1 ? bus.req1_b  : bus.req0_b;
        alu_op = gnt1 ? bus.req1_op : bus.req0_op;
    end

    alu_arb_alu u_alu (
        .a  (alu_a),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    // Next slot contents: refill on grant, empty on a bare drain, else hold.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (gnt0 || gnt1) begin
            state_d = SLOT_HELD;
            owner_d = gnt1;
            data_d  = alu_y;
            ptr_d   = gnt0;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Slot FSM and priority pointer; reset discards any held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            owner_q <= 1'b0;
            data_q  <= '0;
            ptr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q <= state_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.rsp0_valid = (state_q == SLOT_HELD) && !owner_q;
    assign bus.rsp1_valid = (state_q == SLOT_HELD) &&  owner_q;
    assign bus.rsp0_data  = bus.rsp0_valid ? data_q : '0;
    assign bus.rsp1_data  = bus.rsp1_valid ? data_q : '0;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb. Two instances (round-robin and fixed
// priority) see identical stimulus; a small model plus one scoreboard queue per
// instance predicts grants and responses every cycle.
module tb_alu_arb;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_arb_if rr_if ();
    alu_arb_if fp_if ();

    alu_arb #(.RR_EN(1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(rr_if));
    alu_arb #(.RR_EN(0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(fp_if));

    assign fp_if.req0_valid = rr_if.req0_valid;
    assign fp_if.req0_a     = rr_if.req0_a;
    assign fp_if.req0_b     = rr_if.req0_b;
    assign fp_if.req0_op    = rr_if.req0_op;
    assign fp_if.rsp0_ready = rr_if.rsp0_ready;
    assign fp_if.req1_valid = rr_if.req1_valid;
    assign fp_if.req1_a     = rr_if.req1_a;
    assign fp_if.req1_b     = rr_if.req1_b;
    assign fp_if.req1_op    = rr_if.req1_op;
    assign fp_if.rsp1_ready = rr_if.rsp1_ready;

    // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
    logic  m_full  [2];
    logic  m_owner [2];
    logic  m_ptr   [2];
    data_t sb_rr [$];
    data_t sb_fp [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit exceeded");
    end

    function automatic data_t ref_alu(alu_op_e op, data_t a, data_t b);
        case (op)
            OP_ADD:  return data_t'(a + b);
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            default: return a;
        endcase
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_full[d]  = 1'b0;
            m_owner[d] = 1'b0;
            m_ptr[d]   = 1'b0;
        end
        sb_rr.delete();
        sb_fp.delete();
    endtask

    task automatic drive(logic v0, alu_op_e op0, data_t a0, data_t b0,
                         logic v1, alu_op_e op1, data_t a1, data_t b1,
                         logic r0, logic r1);
        rr_if.req0_valid = v0;
        rr_if.req0_op    = op0;
        rr_if.req0_a     = a0;
        rr_if.req0_b     = b0;
        rr_if.req1_valid = v1;
        rr_if.req1_op    = op1;
        rr_if.req1_a     = a1;
        rr_if.req1_b     = b1;
        rr_if.rsp0_ready = r0;
        rr_if.rsp1_ready = r1;
    endtask

    // Compare both instances against the model for the current cycle, advance
    // the model across the coming rising edge, then wait for the falling edge.
    task automatic step(string tag);
        logic    v [2];
        logic    r [2];
        alu_op_e op [2];
        data_t   a [2];
        data_t   b [2];
        logic    rdy [2][2];
        logic    rv  [2][2];
        data_t   rd  [2][2];
        #1;
        v[0] = rr_if.req0_valid; v[1] = rr_if.req1_valid;
        r[0] = rr_if.rsp0_ready; r[1] = rr_if.rsp1_ready;
        op[0] = rr_if.req0_op;   op[1] = rr_if.req1_op;
        a[0] = rr_if.req0_a;     a[1] = rr_if.req1_a;
        b[0] = rr_if.req0_b;     b[1] = rr_if.req1_b;
        rdy[0][0] = rr_if.req0_ready; rdy[0][1] = rr_if.req1_ready;
        rdy[1][0] = fp_if.req0_ready; rdy[1][1] = fp_if.req1_ready;
        rv[0][0]  = rr_if.rsp0_valid; rv[0][1]  = rr_if.rsp1_valid;
        rv[1][0]  = fp_if.rsp0_valid; rv[1][1]  = fp_if.rsp1_valid;
        rd[0][0]  = rr_if.rsp0_data;  rd[0][1]  = rr_if.rsp1_data;
        rd[1][0]  = fp_if.rsp0_data;  rd[1][1]  = fp_if.rsp1_data;
        for (int d = 0; d < 2; d++) begin
            logic  free, g0, g1, ev0, ev1;
            data_t front, res;
            if (d == 0) front = (sb_rr.size() > 0) ? sb_rr[0] : '0;
            else        front = (sb_fp.size() > 0) ? sb_fp[0] : '0;
            free = !m_full[d] || (m_owner[d] ? r[1] : r[0]);
            g0 = 1'b0;
            g1 = 1'b0;
            if (free) begin
                if (v[0] && v[1]) begin
                    if (d == 0 && m_ptr[d]) g1 = 1'b1;
                    else                    g0 = 1'b1;
                end else begin
                    g0 = v[0];
                    g1 = v[1];
                end
            end
            ev0 = m_full[d] && !m_owner[d];
            ev1 = m_full[d] &&  m_owner[d];
            check($sformatf("%s d%0d req0_ready", tag, d), 16'(rdy[d][0]), 16'(g0));
            check($sformatf("%s d%0d req1_ready", tag, d), 16'(rdy[d][1]), 16'(g1));
            check($sformatf("%s d%0d rsp0_valid", tag, d), 16'(rv[d][0]), 16'(ev0));
            check($sformatf("%s d%0d rsp1_valid", tag, d), 16'(rv[d][1]), 16'(ev1));
            check($sformatf("%s d%0d rsp0_data", tag, d), rd[d][0], ev0 ? front : 16'h0);
            check($sformatf("%s d%0d rsp1_data", tag, d), rd[d][1], ev1 ? front : 16'h0);
            if (free && m_full[d]) begin
                if (d == 0) void'(sb_rr.pop_front());
                else        void'(sb_fp.pop_front());
            end
            if (g0 || g1) begin
                res = g1 ? ref_alu(op[1], a[1], b[1]) : ref_alu(op[0], a[0], b[0]);
                if (d == 0) sb_rr.push_back(res);
                else        sb_fp.push_back(res);
                m_owner[d] = g1;
                m_ptr[d]   = g0;
            end
            if (free) m_full[d] = g0 || g1;
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();

        // Reset with both requesters valid: nothing may be granted or valid.
        rst_n = 1'b0;
        drive(1, OP_ADD, 16'h0001, 16'h0001, 1, OP_ADD, 16'h0002, 16'h0002, 1, 1);
        #3;
        check("rst rr req0_ready", 16'(rr_if.req0_ready), 16'h0);
        check("rst rr req1_ready", 16'(rr_if.req1_ready), 16'h0);
        check("rst rr rsp0_valid", 16'(rr_if.rsp0_valid), 16'h0);
        check("rst fp req0_ready", 16'(fp_if.req0_ready), 16'h0);
        check("rst fp rsp1_valid", 16'(fp_if.rsp1_valid), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
        step("idle");

        // ADD wraps modulo 2^16, result visible one edge later, then drains.
        drive(1, OP_ADD, 16'hFFFF, 16'h0002, 0, OP_ADD, 0, 0, 1, 1);
        step("add_acc");
        check("add_wrap_valid", 16'(rr_if.rsp0_valid), 16'h1);
        check("add_wrap_data", rr_if.rsp0_data, 16'h0001);
        drive(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
        step("add_drain");
        check("add_empty", 16'(rr_if.rsp0_valid), 16'h0);

        // Both requesters valid every cycle with responses always consumed.
        for (int i = 0; i < 4; i++) begin
            drive(1, OP_ADD, 16'(i), 16'h0100, 1, OP_XOR, 16'(i), 16'h00F0, 1, 1);
            step($sformatf("both%0d", i));
        end
        drive(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
        step("flush");

        // XOR result for requester 1 held while its consumer stalls.
        drive(0, OP_ADD, 0, 0, 1, OP_XOR, 16'hAAAA, 16'h5555, 0, 0);
        step("xor_acc");
        for (int i = 0; i < 3; i++) begin
            drive(1, OP_PASSA, 16'h1234, 16'hBEEF, 0, OP_XOR, 0, 0, 0, 0);
            step($sformatf("xor_hold%0d", i));
            check("xor_held_data", rr_if.rsp1_data, 16'hFFFF);
        end

        // Requester 1 drains while requester 0's PASSA is granted.
        drive(1, OP_PASSA, 16'h1234, 16'hBEEF, 0, OP_ADD, 0, 0, 0, 1);
        step("pass_acc");
        check("pass_data", rr_if.rsp0_data, 16'h1234);
        check("pass_rsp1_idle", 16'(rr_if.rsp1_valid), 16'h0);

        // Requester 0 drains while requester 1's AND is granted.
        drive(0, OP_ADD, 0, 0, 1, OP_AND, 16'hF0F0, 16'h0FF0, 1, 0);
        step("and_acc");
        check("and_data", rr_if.rsp1_data, 16'h00F0);
        check("and_rsp0_idle", 16'(rr_if.rsp0_valid), 16'h0);

        // Reset mid-hold drops the held result at once, no replay after release.
        drive(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
        step("hold_pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst rr rsp1_valid", 16'(rr_if.rsp1_valid), 16'h0);
        check("midrst fp rsp1_valid", 16'(fp_if.rsp1_valid), 16'h0);
        check("midrst rr rsp1_data", rr_if.rsp1_data, 16'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
        step("post_rst0");
        step("post_rst1");
        // Pointer favours requester 0 after reset.
        drive(1, OP_AND, 16'h00FF, 16'h0F0F, 1, OP_ADD, 16'h0001, 16'h0002, 1, 1);
        step("tie_after_rst");
        check("tie_after_rst_owner", rr_if.rsp0_data, 16'h000F);

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), alu_op_e'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), alu_op_e'($urandom_range(0, 3)),
                  16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step($sformatf("rand%0d", i));
        end
        drive(0, OP_ADD, 0, 0, 0, OP_ADD, 0, 0, 1, 1);
        step("final_drain");
        step("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
